tdc_conversion_sequencer: RTL and testbench
===========================================

# tdc_conversion_sequencer

Sequencer that drives one TOA/TOT/Cal conversion through the TDC encoder per accepted hit, then collects the encoded result. It sits between the pixel hit logic and the encoder. It issues the raw-data latch strobe, waits a programmable settle time for the encoder's combinational path, and issues the encoded-data latch strobe. It captures the resulting codes and error flags into a 4-deep output FIFO with a valid/ready handshake, and keeps saturating hit, drop and error counters for slow control.

## Interface
Parameters:
- FIFO_DEPTH, 4: output FIFO entries; power of two.
- CNT_W, 8: width of the drop and error counters.

Ports:
- CtrlClk  in  1  sole clock; all logic on its rising edge.
- ResetFlag  in  1  asynchronous, active-low reset.
- hitIn  in  1  single-cycle conversion request.
- settleCycles  in  3  wait cycles between rawLatchEn and encLatchEn (0–7). Sampled in IDLE when a hit is accepted.
- errMask  in  3  {Cal,TOA,TOT}. A set bit makes the matching error flag discard the event.
- TOT_code  in  9  encoder output.
- TOA_code  in  10  encoder output.
- Cal_code  in  10  encoder output.
- TOTerrorFlag, TOAerrorFlag, CalerrorFlag  in  1 each  encoder error outputs.
- rawLatchEn  out  1  one-cycle strobe to the raw-data registers.
- encLatchEn  out  1  one-cycle strobe to the encoded-data registers.
- busy  out  1  high in every state except IDLE.
- outData  out  32  {CalErr,TOAErr,TOTErr, TOT_code, TOA_code, Cal_code}, MSB first.
- outValid  out  1  FIFO non-empty.
- outReady  in  1  consumer accepts the head entry when outValid and outReady are both high.
- hitCount  out  16  accepted hits; wraps.
- dropCount  out  CNT_W  rejected or dropped events; saturates at all-ones.
- errCount  out  CNT_W  masked-error discards; saturates at all-ones.

## Operation
- FSM states: IDLE, LATCH_RAW, SETTLE, LATCH_ENC, CAPTURE.
- IDLE:
  - On hitIn, load settleCycles into the settle counter, increment hitCount, and go to LATCH_RAW.
- LATCH_RAW:
  - rawLatchEn = 1.
  - Go to SETTLE if the loaded value ≠ 0, otherwise to LATCH_ENC.
- SETTLE:
  - Decrement the counter each cycle.
  - Leave for LATCH_ENC in the cycle the counter reads 1.
- LATCH_ENC:
  - encLatchEn = 1; go to CAPTURE.
- CAPTURE: sample the code and flag inputs, then:
  - If (flags & errMask) ≠ 0: discard the event and increment errCount.
  - Else if the FIFO is full and no pop occurs in this cycle: drop the event and increment dropCount.
  - Else: push the event.
  - Return to IDLE.
- hitIn while busy is ignored and increments dropCount. A hit in the CAPTURE cycle is also ignored; there is no queuing.
- FIFO:
  - Push and pop in the same cycle are both honoured, including when full (the pop frees the slot) and when empty (the push lands and is not visible until the next cycle).
  - Pointers are FIFO_DEPTH-wide modulo plus a wrap bit.
- Counters: a simultaneous busy-drop and capture-drop increments dropCount by 1 only.
- Reset (async, mid-operation allowed):
  - State goes to IDLE and the FIFO is emptied.
  - All counters are cleared.
  - All outputs go to 0: rawLatchEn, encLatchEn, busy, outValid, outData, hitCount, dropCount, errCount.
  - An in-flight event is lost and not counted.

## Timing
- Hit sampled at edge 0:
  - rawLatchEn is high in cycle 1.
  - encLatchEn is high in cycle 2+N, where N = settleCycles.
  - CAPTURE is in cycle 3+N.
  - outValid rises in cycle 4+N if the FIFO was empty.
- Next hit is accepted no earlier than cycle 4+N; the throughput limit is one event per 4+N cycles.
- outData is registered and held stable while outValid=1 and outReady=0.
- rawLatchEn and encLatchEn are glitch-free register outputs, each exactly one cycle wide.
- busy is high from cycle 1 through cycle 3+N inclusive.

## Structure
- Shared package `tdc_ctrl_pkg`:
  - FSM state enum.
  - Event word width (32) and field offsets.
  - Flag bit order {Cal,TOA,TOT}.
- One sub-module, `tdc_evt_fifo`: synchronous FIFO with parameterised depth and width, providing full/empty and same-cycle push/pop.
- Counters and the FSM live in the top module.

## Test plan
- settleCycles=0, single hitIn, outReady=1: rawLatchEn at cycle 1, encLatchEn at cycle 2, outValid at cycle 4, outData = {3'b000, TOT=9'h055, TOA=10'h12A, Cal=10'h3FF}, hitCount=1.
- settleCycles=7: encLatchEn at cycle 9, outValid at cycle 11; a second hitIn at cycle 5 is ignored, dropCount=1, busy high in cycles 1–10.
- errMask=3'b010, TOAerrorFlag=1: no push, errCount=1. errMask=0 with the same flags: event pushed with outData[30]=1.
- outReady=0, six back-to-back hits: four entries stored, dropCount=2. Then drain with outReady=1: data appears in order and outValid falls after the fourth pop.
- FIFO full, pop and push in the same CAPTURE cycle: no drop, occupancy stays 4.
- ResetFlag asserted low in SETTLE: all outputs 0 immediately (asynchronously). After release, a new hit completes normally with hitCount=1.

Source files
------------

// File: rtl/tdc_ctrl_pkg.sv
// Shared types and event-word layout for the TDC conversion sequencer.
// Flag vectors are ordered {Cal,TOA,TOT} everywhere.
package tdc_ctrl_pkg;

   typedef enum logic [2:0] {
      IDLE      = 3'd0,
      LATCH_RAW = 3'd1,
      SETTLE    = 3'd2,
      LATCH_ENC = 3'd3,
      CAPTURE   = 3'd4
   } seqState_t;

   localparam int EVT_W      = 32;
   localparam int CAL_LSB    = 0;
   localparam int TOA_LSB    = 10;
   localparam int TOT_LSB    = 20;
   localparam int TOTERR_BIT = 29;
   localparam int TOAERR_BIT = 30;
   localparam int CALERR_BIT = 31;

   localparam int FLAG_TOT = 0;
   localparam int FLAG_TOA = 1;
   localparam int FLAG_CAL = 2;

   // The {Cal,TOA,TOT} flag order maps straight onto bits 31..29.
   function automatic logic [EVT_W-1:0] packEvent(input logic [2:0] flags,
                                                  input logic [8:0] tot,
                                                  input logic [9:0] toa,
                                                  input logic [9:0] cal);
      return {flags, tot, toa, cal};
   endfunction

endpackage

// File: rtl/tdc_evt_fifo.sv
// Synchronous event FIFO with wrap-bit pointers; a pop frees a slot for a
// push in the same cycle even when full.
module tdc_evt_fifo #(
   parameter int DEPTH = 4,
   parameter int WIDTH = 32
) (
   input  logic             CtrlClk,
   input  logic             ResetFlag,
   input  logic             push,
   input  logic             pop,
   input  logic [WIDTH-1:0] wrData,
   output logic [WIDTH-1:0] rdData,
   output logic             full,
   output logic             empty
);

   localparam int AW = $clog2(DEPTH);
   localparam logic [AW:0] PTR_ONE = (AW+1)'(1);

   logic [AW:0]      wrPtr_r;
   logic [AW:0]      rdPtr_r;
   logic [WIDTH-1:0] mem_r [DEPTH];
   logic             doPush_s;
   logic             doPop_s;

   assign empty    = (wrPtr_r == rdPtr_r);
   assign full     = (wrPtr_r[AW] != rdPtr_r[AW]) && (wrPtr_r[AW-1:0] == rdPtr_r[AW-1:0]);
   assign doPop_s  = pop & ~empty;
   assign doPush_s = push & (~full | doPop_s);
   assign rdData   = mem_r[rdPtr_r[AW-1:0]];

   // Pointer and storage update; storage is cleared so the head reads zero after reset.
   always_ff @(posedge CtrlClk or negedge ResetFlag) begin
      if (!ResetFlag) begin
         wrPtr_r <= '0;
         rdPtr_r <= '0;
         for (int i = 0; i < DEPTH; i++) begin
            mem_r[i] <= '0;
         end
      end else begin
         if (doPush_s) begin
            mem_r[wrPtr_r[AW-1:0]] <= wrData;
            wrPtr_r                <= wrPtr_r + PTR_ONE;
         end
         if (doPop_s) begin
            rdPtr_r <= rdPtr_r + PTR_ONE;
         end
      end
   end

endmodule

// File: rtl/tdc_conversion_sequencer.sv
// Drives one raw-latch / settle / encoded-latch conversion per accepted hit,
// queues the encoded result and keeps slow-control hit/drop/error counters.
module tdc_conversion_sequencer
   import tdc_ctrl_pkg::*;
#(
   parameter int FIFO_DEPTH = 4,
   parameter int CNT_W      = 8
) (
   input  logic             CtrlClk,
   input  logic             ResetFlag,
   input  logic             hitIn,
   input  logic [2:0]       settleCycles,
   input  logic [2:0]       errMask,
   input  logic [8:0]       TOT_code,
   input  logic [9:0]       TOA_code,
   input  logic [9:0]       Cal_code,
   input  logic             TOTerrorFlag,
   input  logic             TOAerrorFlag,
   input  logic             CalerrorFlag,
   output logic             rawLatchEn,
   output logic             encLatchEn,
   output logic             busy,
   output logic [31:0]      outData,
   output logic             outValid,
   input  logic             outReady,
   output logic [15:0]      hitCount,
   output logic [CNT_W-1:0] dropCount,
   output logic [CNT_W-1:0] errCount
);

   localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};
   localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

   seqState_t        state_r;
   logic [2:0]       settleCnt_r;
   logic             rawLatchEn_r;
   logic             encLatchEn_r;
   logic             busy_r;
   logic [15:0]      hitCount_r;
   logic [CNT_W-1:0] dropCount_r;
   logic [CNT_W-1:0] errCount_r;

   logic [2:0]       flags_s;
   logic             capture_s;
   logic             accept_s;
   logic             errHit_s;
   logic             pop_s;
   logic             push_s;
   logic             busyDrop_s;
   logic             capDrop_s;
   logic             fifoFull_s;
   logic             fifoEmpty_s;
   logic [EVT_W-1:0] evtWord_s;

   assign flags_s    = {CalerrorFlag, TOAerrorFlag, TOTerrorFlag};
   assign capture_s  = (state_r == CAPTURE);
   assign accept_s   = hitIn & (state_r == IDLE);
   assign busyDrop_s = hitIn & (state_r != IDLE);
   assign errHit_s   = capture_s & (|(flags_s & errMask));
   assign pop_s      = outReady & ~fifoEmpty_s;
   assign push_s     = capture_s & ~errHit_s;
   assign capDrop_s  = push_s & fifoFull_s & ~pop_s;
   assign evtWord_s  = packEvent(flags_s, TOT_code, TOA_code, Cal_code);

   // Conversion FSM with registered strobes and busy.
   always_ff @(posedge CtrlClk or negedge ResetFlag) begin
      if (!ResetFlag) begin
         state_r      <= IDLE;
         settleCnt_r  <= 3'd0;
         rawLatchEn_r <= 1'b0;
         encLatchEn_r <= 1'b0;
         busy_r       <= 1'b0;
      end else begin
         rawLatchEn_r <= 1'b0;
         encLatchEn_r <= 1'b0;
         case (state_r)
            IDLE: begin
               if (hitIn) begin
                  settleCnt_r  <= settleCycles;
                  rawLatchEn_r <= 1'b1;
                  busy_r       <= 1'b1;
                  state_r      <= LATCH_RAW;
               end else begin
                  busy_r <= 1'b0;
               end
            end
            LATCH_RAW: begin
               busy_r <= 1'b1;
               if (settleCnt_r != 3'd0) begin
                  state_r <= SETTLE;
               end else begin
                  encLatchEn_r <= 1'b1;
                  state_r      <= LATCH_ENC;
               end
            end
            SETTLE: begin
               busy_r      <= 1'b1;
               settleCnt_r <= settleCnt_r - 3'd1;
               // A zero count here cannot happen normally; exit rather than wrap.
               if (settleCnt_r <= 3'd1) begin
                  encLatchEn_r <= 1'b1;
                  state_r      <= LATCH_ENC;
               end else begin
                  state_r <= SETTLE;
               end
            end
            LATCH_ENC: begin
               busy_r  <= 1'b1;
               state_r <= CAPTURE;
            end
            CAPTURE: begin
               busy_r  <= 1'b0;
               state_r <= IDLE;
            end
            default: begin
               busy_r  <= 1'b0;
               state_r <= IDLE;
            end
         endcase
      end
   end

   // Slow-control counters; a busy drop and a capture drop together count once.
   always_ff @(posedge CtrlClk or negedge ResetFlag) begin
      if (!ResetFlag) begin
         hitCount_r  <= 16'd0;
         dropCount_r <= '0;
         errCount_r  <= '0;
      end else begin
         if (accept_s) begin
            hitCount_r <= hitCount_r + 16'd1;
         end
         if ((busyDrop_s | capDrop_s) && (dropCount_r != CNT_MAX)) begin
            dropCount_r <= dropCount_r + CNT_ONE;
         end
         if (errHit_s && (errCount_r != CNT_MAX)) begin
            errCount_r <= errCount_r + CNT_ONE;
         end
      end
   end

   tdc_evt_fifo #(
      .DEPTH (FIFO_DEPTH),
      .WIDTH (EVT_W)
   ) uFifo (
      .CtrlClk   (CtrlClk),
      .ResetFlag (ResetFlag),
      .push      (push_s),
      .pop       (pop_s),
      .wrData    (evtWord_s),
      .rdData    (outData),
      .full      (fifoFull_s),
      .empty     (fifoEmpty_s)
   );

   assign rawLatchEn = rawLatchEn_r;
   assign encLatchEn = encLatchEn_r;
   assign busy       = busy_r;
   assign outValid   = ~fifoEmpty_s;
   assign hitCount   = hitCount_r;
   assign dropCount  = dropCount_r;
   assign errCount   = errCount_r;

endmodule

// File: tb/tb_tdc_conversion_sequencer.sv
// Directed self-checking bench for tdc_conversion_sequencer.
module tb_tdc_conversion_sequencer;

   logic        CtrlClk = 1'b0;
   logic        ResetFlag = 1'b0;
   logic        hitIn = 1'b0;
   logic [2:0]  settleCycles = 3'd0;
   logic [2:0]  errMask = 3'd0;
   logic [8:0]  TOT_code = 9'd0;
   logic [9:0]  TOA_code = 10'd0;
   logic [9:0]  Cal_code = 10'd0;
   logic        TOTerrorFlag = 1'b0;
   logic        TOAerrorFlag = 1'b0;
   logic        CalerrorFlag = 1'b0;
   logic        outReady = 1'b0;
   logic        rawLatchEn;
   logic        encLatchEn;
   logic        busy;
   logic [31:0] outData;
   logic        outValid;
   logic [15:0] hitCount;
   logic [7:0]  dropCount;
   logic [7:0]  errCount;

   int nCmp = 0;
   int nBad = 0;

   logic [8:0] totTab [6] = '{9'h001, 9'h0F2, 9'h133, 9'h044, 9'h1F5, 9'h006};
   logic [9:0] toaTab [6] = '{10'h011, 10'h3A2, 10'h0C3, 10'h204, 10'h155, 10'h2AA};
   logic [9:0] calTab [6] = '{10'h100, 10'h0FF, 10'h301, 10'h022, 10'h3F0, 10'h0AB};

   tdc_conversion_sequencer dut (
      .CtrlClk      (CtrlClk),
      .ResetFlag    (ResetFlag),
      .hitIn        (hitIn),
      .settleCycles (settleCycles),
      .errMask      (errMask),
      .TOT_code     (TOT_code),
      .TOA_code     (TOA_code),
      .Cal_code     (Cal_code),
      .TOTerrorFlag (TOTerrorFlag),
      .TOAerrorFlag (TOAerrorFlag),
      .CalerrorFlag (CalerrorFlag),
      .rawLatchEn   (rawLatchEn),
      .encLatchEn   (encLatchEn),
      .busy         (busy),
      .outData      (outData),
      .outValid     (outValid),
      .outReady     (outReady),
      .hitCount     (hitCount),
      .dropCount    (dropCount),
      .errCount     (errCount)
   );

   always #5 CtrlClk = ~CtrlClk;

   task automatic tick;
      @(posedge CtrlClk);
      #1;
   endtask

   task automatic doReset;
      ResetFlag = 1'b0;
      hitIn = 1'b0;
      outReady = 1'b0;
      errMask = 3'd0;
      settleCycles = 3'd0;
      {CalerrorFlag, TOAerrorFlag, TOTerrorFlag} = 3'b000;
      repeat (2) tick();
      ResetFlag = 1'b1;
      tick();
   endtask

   // Hit in the current cycle; returns in cycle 4+n of that conversion.
   task automatic runConv(input int n);
      hitIn = 1'b1;
      tick();
      hitIn = 1'b0;
      repeat (n + 3) tick();
   endtask

   task automatic loadTab(input int k);
      TOT_code = totTab[k];
      TOA_code = toaTab[k];
      Cal_code = calTab[k];
   endtask

   task automatic test_reset;
      doReset();
      nCmp++;
      if ({rawLatchEn, encLatchEn, busy, outValid} !== 4'b0000) begin
         nBad++; $display("FAIL reset_ctrl: got %b want 0000", {rawLatchEn, encLatchEn, busy, outValid});
      end
      nCmp++;
      if (outData !== 32'd0) begin
         nBad++; $display("FAIL reset_data: got %h want 00000000", outData);
      end
      nCmp++;
      if ({hitCount, dropCount, errCount} !== 32'd0) begin
         nBad++; $display("FAIL reset_counters: got %h want 0", {hitCount, dropCount, errCount});
      end
   endtask

   task automatic test_single;
      doReset();
      TOT_code = 9'h055; TOA_code = 10'h12A; Cal_code = 10'h3FF;
      outReady = 1'b1;
      hitIn = 1'b1;
      tick();
      hitIn = 1'b0;
      nCmp++;
      if ({rawLatchEn, encLatchEn, busy} !== 3'b101) begin
         nBad++; $display("FAIL single_c1: got %b want 101", {rawLatchEn, encLatchEn, busy});
      end
      tick();
      nCmp++;
      if ({rawLatchEn, encLatchEn, busy} !== 3'b011) begin
         nBad++; $display("FAIL single_c2: got %b want 011", {rawLatchEn, encLatchEn, busy});
      end
      tick();
      nCmp++;
      if ({encLatchEn, busy, outValid} !== 3'b010) begin
         nBad++; $display("FAIL single_c3: got %b want 010", {encLatchEn, busy, outValid});
      end
      tick();
      nCmp++;
      if ({busy, outValid} !== 2'b01) begin
         nBad++; $display("FAIL single_c4_valid: got %b want 01", {busy, outValid});
      end
      nCmp++;
      if (outData !== {3'b000, 9'h055, 10'h12A, 10'h3FF}) begin
         nBad++; $display("FAIL single_data: got %h want %h", outData, {3'b000, 9'h055, 10'h12A, 10'h3FF});
      end
      nCmp++;
      if (hitCount !== 16'd1) begin
         nBad++; $display("FAIL single_hits: got %0d want 1", hitCount);
      end
      tick();
      nCmp++;
      if (outValid !== 1'b0) begin
         nBad++; $display("FAIL single_popped: got %b want 0", outValid);
      end
   endtask

   task automatic test_settle7;
      doReset();
      settleCycles = 3'd7;
      outReady = 1'b1;
      hitIn = 1'b1;
      tick();
      hitIn = 1'b0;
      for (int c = 1; c <= 11; c++) begin
         nCmp++;
         if ({busy, rawLatchEn, encLatchEn, outValid} !== {(c <= 10), (c == 1), (c == 9), (c == 11)}) begin
            nBad++;
            $display("FAIL settle7_cycle%0d: got %b want %b", c, {busy, rawLatchEn, encLatchEn, outValid},
                     {(c <= 10), (c == 1), (c == 9), (c == 11)});
         end
         hitIn = (c == 5);
         tick();
      end
      nCmp++;
      if (dropCount !== 8'd1) begin
         nBad++; $display("FAIL settle7_drop: got %0d want 1", dropCount);
      end
      nCmp++;
      if (hitCount !== 16'd1) begin
         nBad++; $display("FAIL settle7_hits: got %0d want 1", hitCount);
      end
   endtask

   task automatic test_err_mask;
      doReset();
      TOT_code = 9'h1A3; TOA_code = 10'h2C4; Cal_code = 10'h015;
      TOAerrorFlag = 1'b1;
      errMask = 3'b010;
      runConv(0);
      nCmp++;
      if ({outValid, errCount, dropCount} !== {1'b0, 8'd1, 8'd0}) begin
         nBad++; $display("FAIL err_discard: got v=%b e=%0d d=%0d want v=0 e=1 d=0", outValid, errCount, dropCount);
      end
      errMask = 3'b000;
      runConv(0);
      nCmp++;
      if (outValid !== 1'b1 || outData[30] !== 1'b1) begin
         nBad++; $display("FAIL err_unmasked: got v=%b bit30=%b want v=1 bit30=1", outValid, outData[30]);
      end
      nCmp++;
      if (outData !== {3'b010, 9'h1A3, 10'h2C4, 10'h015}) begin
         nBad++; $display("FAIL err_data: got %h want %h", outData, {3'b010, 9'h1A3, 10'h2C4, 10'h015});
      end
      nCmp++;
      if (errCount !== 8'd1) begin
         nBad++; $display("FAIL err_count_held: got %0d want 1", errCount);
      end
      TOAerrorFlag = 1'b0;
   endtask

   task automatic test_back_to_back;
      doReset();
      for (int i = 0; i < 6; i++) begin
         loadTab(i);
         runConv(0);
      end
      nCmp++;
      if ({hitCount, dropCount, errCount} !== {16'd6, 8'd2, 8'd0}) begin
         nBad++; $display("FAIL b2b_counters: got h=%0d d=%0d e=%0d want 6 2 0", hitCount, dropCount, errCount);
      end
      outReady = 1'b1;
      for (int k = 0; k < 4; k++) begin
         nCmp++;
         if (outValid !== 1'b1 || outData !== {3'b000, totTab[k], toaTab[k], calTab[k]}) begin
            nBad++; $display("FAIL b2b_entry%0d: got v=%b %h want v=1 %h", k, outValid, outData,
                             {3'b000, totTab[k], toaTab[k], calTab[k]});
         end
         tick();
      end
      nCmp++;
      if (outValid !== 1'b0) begin
         nBad++; $display("FAIL b2b_drained: got %b want 0", outValid);
      end
      outReady = 1'b0;
   endtask

   task automatic test_full_pushpop;
      int cnt;
      doReset();
      for (int i = 0; i < 4; i++) begin
         loadTab(i);
         runConv(0);
      end
      loadTab(4);
      hitIn = 1'b1;
      tick();
      hitIn = 1'b0;
      tick();
      tick();
      outReady = 1'b1;
      tick();
      outReady = 1'b0;
      nCmp++;
      if ({hitCount, dropCount} !== {16'd5, 8'd0}) begin
         nBad++; $display("FAIL full_pp_counters: got h=%0d d=%0d want 5 0", hitCount, dropCount);
      end
      outReady = 1'b1;
      cnt = 0;
      while (outValid === 1'b1 && cnt < 8) begin
         nCmp++;
         if (cnt < 4 && outData !== {3'b000, totTab[cnt+1], toaTab[cnt+1], calTab[cnt+1]}) begin
            nBad++; $display("FAIL full_pp_entry%0d: got %h want %h", cnt, outData,
                             {3'b000, totTab[cnt+1], toaTab[cnt+1], calTab[cnt+1]});
         end
         cnt++;
         tick();
      end
      nCmp++;
      if (cnt !== 4) begin
         nBad++; $display("FAIL full_pp_occupancy: got %0d want 4", cnt);
      end
      outReady = 1'b0;
   endtask

   task automatic test_async_reset;
      doReset();
      loadTab(2);
      runConv(0);
      settleCycles = 3'd5;
      hitIn = 1'b1;
      tick();
      hitIn = 1'b0;
      tick();
      tick();
      nCmp++;
      if ({busy, outValid, hitCount} !== {1'b1, 1'b1, 16'd2}) begin
         nBad++; $display("FAIL areset_pre: got b=%b v=%b h=%0d want 1 1 2", busy, outValid, hitCount);
      end
      #2;
      ResetFlag = 1'b0;
      #1;
      nCmp++;
      if ({rawLatchEn, encLatchEn, busy, outValid, outData, hitCount, dropCount, errCount} !== 68'd0) begin
         nBad++; $display("FAIL areset_outputs: got b=%b v=%b d=%h h=%0d want all 0", busy, outValid, outData, hitCount);
      end
      tick();
      tick();
      #2;
      ResetFlag = 1'b1;
      tick();
      settleCycles = 3'd0;
      loadTab(5);
      runConv(0);
      nCmp++;
      if ({hitCount, dropCount, errCount, outValid} !== {16'd1, 8'd0, 8'd0, 1'b1}) begin
         nBad++; $display("FAIL areset_after: got h=%0d d=%0d e=%0d v=%b want 1 0 0 1", hitCount, dropCount, errCount, outValid);
      end
      nCmp++;
      if (outData !== {3'b000, totTab[5], toaTab[5], calTab[5]}) begin
         nBad++; $display("FAIL areset_data: got %h want %h", outData, {3'b000, totTab[5], toaTab[5], calTab[5]});
      end
   endtask

   initial begin
      test_reset();
      test_single();
      test_settle7();
      test_err_mask();
      test_back_to_back();
      test_full_pushpop();
      test_async_reset();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCmp, nBad);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout want completion");
      $fatal(1, "watchdog expired");
   end

endmodule
